// File: rtl/tetris_2048_core.sv
// Column-drop 2048 game core: 4x4 exponent board, cursor, chained merges.
// Optional TETRIS2048_SPAWN4_EN lets the LFSR spawn "4" tiles.
module tetris_2048_core (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_l,
  input  logic        btn_r,
  input  logic        btn_drop,
  output logic [79:0] board_flat,
  output logic [15:0] score,
  output logic        game_over,
  output logic [1:0]  cursor_col,
  output logic [4:0]  spawn_val
);

  typedef enum logic [2:0] {
    IDLE,
    LAND,
    MERGE,
    SPAWN,
    OVER
  } state_t;

  state_t      state;
  logic        btn_l_q;
  logic        btn_r_q;
  logic        btn_drop_q;
  logic [15:0] lfsr;
  logic [1:0]  col_q;
  logic [1:0]  pos;

  logic        l_ev;
  logic        r_ev;
  logic        drop_ev;
  logic        lfsr_fb;
  logic [1:0]  land_row;
  logic [4:0]  top_cell;
  logic [4:0]  cur_cell;
  logic [4:0]  below_cell;
  logic        can_merge;
  logic [4:0]  merged;
  logic [15:0] gain;
  logic [16:0] sum;
  logic [15:0] score_next;

  function automatic logic [6:0] idx(
    input logic [1:0] r,
    input logic [1:0] c
  );
    return 7'({r, c}) * 7'd5;
  endfunction

  assign l_ev    = btn_l & ~btn_l_q;
  assign r_ev    = btn_r & ~btn_r_q;
  assign drop_ev = btn_drop & ~btn_drop_q;
  assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

  always_comb begin
    land_row = 2'd0;
    for (int r = 0; r < 4; r++) begin
      if (board_flat[idx(2'(r), col_q) +: 5] == 5'd0)
        land_row = 2'(r);
    end
    top_cell   = board_flat[idx(2'd0, cursor_col) +: 5];
    cur_cell   = board_flat[idx(pos, col_q) +: 5];
    below_cell = board_flat[idx(pos + 2'd1, col_q) +: 5];
    can_merge  = (pos != 2'd3) && (below_cell == cur_cell);
    merged     = (below_cell == 5'd31) ? 5'd31
                                       : below_cell + 5'd1;
    // 2^16 and above no longer fit, so they pin the score
    gain       = merged[4] ? 16'hFFFF
                           : (16'd1 << merged[3:0]);
    sum        = {1'b0, score} + {1'b0, gain};
    score_next = sum[16] ? 16'hFFFF : sum[15:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      btn_l_q    <= 1'b0;
      btn_r_q    <= 1'b0;
      btn_drop_q <= 1'b0;
      lfsr       <= 16'hACE1;
      col_q      <= 2'd0;
      pos        <= 2'd0;
      board_flat <= '0;
      score      <= 16'd0;
      game_over  <= 1'b0;
      cursor_col <= 2'd0;
      spawn_val  <= 5'd1;
    end else begin
      btn_l_q    <= btn_l;
      btn_r_q    <= btn_r;
      btn_drop_q <= btn_drop;
      lfsr       <= {lfsr[14:0], lfsr_fb};
      unique case (state)
        IDLE: begin
          if (drop_ev) begin
            if (top_cell != 5'd0) begin
              state     <= OVER;
              game_over <= 1'b1;
            end else begin
              col_q <= cursor_col;
              state <= LAND;
            end
          end else if (l_ev && !r_ev) begin
            if (cursor_col != 2'd0)
              cursor_col <= cursor_col - 2'd1;
          end else if (r_ev && !l_ev) begin
            if (cursor_col != 2'd3)
              cursor_col <= cursor_col + 2'd1;
          end
        end
        LAND: begin
          board_flat[idx(land_row, col_q) +: 5] <= spawn_val;
          pos   <= land_row;
          state <= MERGE;
        end
        MERGE: begin
          if (can_merge) begin
            board_flat[idx(pos + 2'd1, col_q) +: 5] <= merged;
            board_flat[idx(pos, col_q) +: 5] <= 5'd0;
            score <= score_next;
            pos   <= pos + 2'd1;
          end else begin
            state <= SPAWN;
          end
        end
        SPAWN: begin
`ifdef TETRIS2048_SPAWN4_EN
          spawn_val <= (lfsr[1:0] == 2'b11) ? 5'd2 : 5'd1;
`else
          spawn_val <= 5'd1;
`endif
          state <= IDLE;
        end
        OVER: begin
          state <= OVER;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tetris_2048_core.sv
// Scoreboard bench for tetris_2048_core (default deterministic spawn build).
// A behavioural model predicts board/score/flag after every drop.
module tb_tetris_2048_core;

  logic        clk;
  logic        rst;
  logic        btn_l;
  logic        btn_r;
  logic        btn_drop;
  logic [79:0] board_flat;
  logic [15:0] score;
  logic        game_over;
  logic [1:0]  cursor_col;
  logic [4:0]  spawn_val;

  typedef struct {
    logic [79:0] board;
    logic [15:0] score;
    logic        go;
  } exp_t;

  exp_t sb[$];
  int   mboard[4][4];
  int   mscore;
  bit   mgo;
  int   mcur;
  int   pass_cnt;
  int   total_cnt;

  tetris_2048_core dut (
    .clk        (clk),
    .rst        (rst),
    .btn_l      (btn_l),
    .btn_r      (btn_r),
    .btn_drop   (btn_drop),
    .board_flat (board_flat),
    .score      (score),
    .game_over  (game_over),
    .cursor_col (cursor_col),
    .spawn_val  (spawn_val)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [79:0] pack_board();
    logic [79:0] b;
    b = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        b[(r*4+c)*5 +: 5] = 5'(mboard[r][c]);
    return b;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        mboard[r][c] = 0;
    mscore = 0;
    mgo = 0;
    mcur = 0;
    sb.delete();
  endtask

  task automatic model_drop(input int col);
    int p;
    int e;
    int g;
    if (mgo) return;
    if (mboard[0][col] != 0) begin
      mgo = 1;
      return;
    end
    p = 0;
    for (int r = 3; r >= 0; r--)
      if (mboard[r][col] == 0) begin
        p = r;
        break;
      end
    mboard[p][col] = 1;
    while (p < 3 && mboard[p+1][col] == mboard[p][col]) begin
      e = mboard[p+1][col] + 1;
      if (e > 31) e = 31;
      mboard[p+1][col] = e;
      mboard[p][col] = 0;
      g = (e >= 16) ? 65535 : (1 << e);
      mscore = mscore + g;
      if (mscore > 65535) mscore = 65535;
      p = p + 1;
    end
  endtask

  task automatic model_move(input bit l, input bit r);
    if (mgo) return;
    if (l && !r && mcur > 0) mcur = mcur - 1;
    if (r && !l && mcur < 3) mcur = mcur + 1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    btn_l = 1'b0;
    btn_r = 1'b0;
    btn_drop = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic press(input bit l, input bit r, input bit d);
    @(negedge clk);
    btn_l = l;
    btn_r = r;
    btn_drop = d;
    @(negedge clk);
    btn_l = 1'b0;
    btn_r = 1'b0;
    btn_drop = 1'b0;
    if (l || r) model_move(l, r);
  endtask

  task automatic drive_drop();
    exp_t e;
    press(1'b0, 1'b0, 1'b1);
    model_drop(mcur);
    e.board = pack_board();
    e.score = 16'(mscore);
    e.go = mgo;
    sb.push_back(e);
    repeat (8) @(negedge clk);
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    total_cnt++;
    if (board_flat !== 80'd0)
      $display("FAIL rst_board got %h want 0", board_flat);
    else pass_cnt++;
    total_cnt++;
    if (score !== 16'd0 || game_over !== 1'b0)
      $display("FAIL rst_score got %0d/%b want 0/0",
               score, game_over);
    else pass_cnt++;
    total_cnt++;
    if (cursor_col !== 2'd0 || spawn_val !== 5'd1)
      $display("FAIL rst_cur got %0d/%0d want 0/1",
               cursor_col, spawn_val);
    else pass_cnt++;
  endtask

  task automatic test_cursor();
    for (int i = 0; i < 5; i++) begin
      press(1'b0, 1'b1, 1'b0);
      total_cnt++;
      if (cursor_col !== 2'(mcur))
        $display("FAIL cur_r%0d got %0d want %0d",
                 i, cursor_col, mcur);
      else pass_cnt++;
    end
    total_cnt++;
    if (cursor_col !== 2'd3)
      $display("FAIL cur_sat_r got %0d want 3", cursor_col);
    else pass_cnt++;
    for (int i = 0; i < 5; i++) begin
      press(1'b1, 1'b0, 1'b0);
      total_cnt++;
      if (cursor_col !== 2'(mcur))
        $display("FAIL cur_l%0d got %0d want %0d",
                 i, cursor_col, mcur);
      else pass_cnt++;
    end
    press(1'b0, 1'b1, 1'b0);
    press(1'b1, 1'b1, 1'b0);
    total_cnt++;
    if (cursor_col !== 2'd1)
      $display("FAIL cur_both got %0d want 1", cursor_col);
    else pass_cnt++;
    press(1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_drop();
    exp_t e;
    drive_drop();
    e = sb.pop_front();
    total_cnt++;
    if (board_flat !== e.board || board_flat[64:60] !== 5'd1)
      $display("FAIL drop_c0 got %h want %h", board_flat, e.board);
    else pass_cnt++;
    press(1'b0, 1'b1, 1'b0);
    drive_drop();
    e = sb.pop_front();
    total_cnt++;
    if (board_flat !== e.board || board_flat[69:65] !== 5'd1)
      $display("FAIL drop_c1 got %h want %h", board_flat, e.board);
    else pass_cnt++;
    total_cnt++;
    if (score !== e.score || score !== 16'd0)
      $display("FAIL drop_score got %0d want 0", score);
    else pass_cnt++;
    press(1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_merge();
    exp_t e;
    drive_drop();
    e = sb.pop_front();
    total_cnt++;
    if (board_flat !== e.board || board_flat[64:60] !== 5'd2
        || board_flat[44:40] !== 5'd0)
      $display("FAIL merge_board got %h want %h",
               board_flat, e.board);
    else pass_cnt++;
    total_cnt++;
    if (score !== e.score || score !== 16'd4)
      $display("FAIL merge_score got %0d want 4", score);
    else pass_cnt++;
  endtask

  task automatic test_chain();
    exp_t e;
    drive_drop();
    e = sb.pop_front();
    total_cnt++;
    if (board_flat !== e.board || board_flat[44:40] !== 5'd1)
      $display("FAIL chain_pre got %h want %h", board_flat, e.board);
    else pass_cnt++;
    drive_drop();
    e = sb.pop_front();
    total_cnt++;
    if (board_flat !== e.board || board_flat[64:60] !== 5'd3)
      $display("FAIL chain_board got %h want %h",
               board_flat, e.board);
    else pass_cnt++;
    total_cnt++;
    if (score !== e.score || score !== 16'd16)
      $display("FAIL chain_score got %0d want 16", score);
    else pass_cnt++;
  endtask

  task automatic test_game_over();
    exp_t e;
    logic [79:0] snap;
    apply_reset();
    for (int i = 0; i < 15; i++) begin
      drive_drop();
      e = sb.pop_front();
      total_cnt++;
      if (board_flat !== e.board || score !== e.score)
        $display("FAIL fill%0d got %h/%0d want %h/%0d",
                 i, board_flat, score, e.board, e.score);
      else pass_cnt++;
    end
    total_cnt++;
    if (score !== 16'd68 || board_flat[64:60] !== 5'd4
        || board_flat[4:0] !== 5'd1)
      $display("FAIL fill_final got %h/%0d want col0 4321/68",
               board_flat, score);
    else pass_cnt++;
    snap = board_flat;
    press(1'b0, 1'b0, 1'b1);
    model_drop(mcur);
    total_cnt++;
    if (game_over !== 1'b1 || game_over !== mgo)
      $display("FAIL go_latency got %b want 1", game_over);
    else pass_cnt++;
    press(1'b0, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    total_cnt++;
    if (cursor_col !== 2'd0)
      $display("FAIL go_cursor got %0d want 0", cursor_col);
    else pass_cnt++;
    drive_drop();
    e = sb.pop_front();
    total_cnt++;
    if (board_flat !== snap || board_flat !== e.board
        || score !== 16'd68 || game_over !== 1'b1)
      $display("FAIL go_frozen got %h/%0d want %h/68",
               board_flat, score, snap);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_op();
    exp_t e;
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      drive_drop();
      e = sb.pop_front();
    end
    total_cnt++;
    if (board_flat !== e.board)
      $display("FAIL mid_setup got %h want %h", board_flat, e.board);
    else pass_cnt++;
    press(1'b0, 1'b0, 1'b1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    total_cnt++;
    if (board_flat !== 80'd0 || score !== 16'd0
        || game_over !== 1'b0 || spawn_val !== 5'd1)
      $display("FAIL mid_rst got %h/%0d want 0/0", board_flat, score);
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    drive_drop();
    e = sb.pop_front();
    total_cnt++;
    if (board_flat !== e.board || score !== e.score)
      $display("FAIL mid_after got %h/%0d want %h/%0d",
               board_flat, score, e.board, e.score);
    else pass_cnt++;
  endtask

  initial begin
    pass_cnt = 0;
    total_cnt = 0;
    rst = 1'b1;
    btn_l = 1'b0;
    btn_r = 1'b0;
    btn_drop = 1'b0;
    test_reset();
    test_cursor();
    test_drop();
    test_merge();
    test_chain();
    test_game_over();
    test_reset_mid_op();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
